// File: rtl/id_ex_hazard.sv
// ID/EX pipeline register with load-use hazard detection, flush and halt handling.
// A load in EX whose destination is read by the decode instruction holds the front
// end for one cycle. During that cycle a bubble goes into EX. Taken branches squash
// decode. HLT freezes the front end once it has reached EX.
module id_ex_hazard (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  IF_ID_Opcode,
  input  logic [3:0]  IF_ID_Rs,
  input  logic [3:0]  IF_ID_Rt,
  input  logic [3:0]  IF_ID_Rd,
  input  logic [15:0] ID_Rs_Data,
  input  logic [15:0] ID_Rt_Data,
  input  logic [15:0] ID_Imm,
  input  logic        ID_Flush,
  output logic [3:0]  ID_EX_Opcode,
  output logic [3:0]  ID_EX_Rs,
  output logic [3:0]  ID_EX_Rt,
  output logic [3:0]  ID_EX_Rd,
  output logic [15:0] ID_EX_Rs_Data,
  output logic [15:0] ID_EX_Rt_Data,
  output logic [15:0] ID_EX_Imm,
  output logic        ID_EX_Valid,
  output logic        Stall,
  output logic        Halted,
  output logic [15:0] Stall_Cnt
);

  localparam logic [3:0] OP_BUBBLE = 4'b0000;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  // ID/EX state
  logic [3:0]  opcode_reg, rs_reg, rt_reg, rd_reg;
  logic [15:0] rs_data_reg, rt_data_reg, imm_reg;
  logic        valid_reg;
  logic        halted_reg;
  logic [15:0] stall_cnt_reg;

  logic [3:0]  opcode_next, rs_next, rt_next, rd_next;
  logic [15:0] rs_data_next, rt_data_next, imm_next;
  logic        valid_next;
  logic        halted_next;
  logic [15:0] stall_cnt_next;

  // Per-opcode source-use maps. A store (1001) reads Rt only as store data, and
  // that data is forwarded MEM-to-MEM, so Rt is left out of its map.
  logic [15:0] uses_rs_map;
  logic [15:0] uses_rt_map;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_src_map
      assign uses_rs_map[gi] = !((gi == 12) || (gi == 14) || (gi == 15));
      assign uses_rt_map[gi] = (gi <= 3) || (gi == 7);
    end
  endgenerate

  logic rs_hit, rt_hit, load_use, stall;

  // Load-use detection: a valid load in EX writing a nonzero register read by decode
  always_comb begin
    rs_hit   = uses_rs_map[IF_ID_Opcode] && (IF_ID_Rs == rd_reg);
    rt_hit   = uses_rt_map[IF_ID_Opcode] && (IF_ID_Rt == rd_reg);
    load_use = valid_reg && (opcode_reg == OP_LW) && (rd_reg != 4'd0) && (rs_hit || rt_hit);
    // A flush or halt already inserts a bubble, so the stall is suppressed.
    stall    = load_use && !ID_Flush && !halted_reg;
  end

  // Next-state selection: bubble on halt/flush/stall, otherwise capture decode
  always_comb begin
    opcode_next    = OP_BUBBLE;
    rs_next        = 4'd0;
    rt_next        = 4'd0;
    rd_next        = 4'd0;
    rs_data_next   = 16'd0;
    rt_data_next   = 16'd0;
    imm_next       = 16'd0;
    valid_next     = 1'b0;
    halted_next    = halted_reg;
    stall_cnt_next = stall_cnt_reg;

    if (!halted_reg && !ID_Flush && !stall) begin
      opcode_next  = IF_ID_Opcode;
      rs_next      = IF_ID_Rs;
      rt_next      = IF_ID_Rt;
      rd_next      = IF_ID_Rd;
      rs_data_next = ID_Rs_Data;
      rt_data_next = ID_Rt_Data;
      imm_next     = ID_Imm;
      valid_next   = 1'b1;
      if (IF_ID_Opcode == OP_HLT) begin
        halted_next = 1'b1;
      end
    end

    if (stall && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_next = stall_cnt_reg + 16'd1;
    end
  end

  // State registers; reset loads a bubble and clears halt and the stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_reg    <= OP_BUBBLE;
      rs_reg        <= 4'd0;
      rt_reg        <= 4'd0;
      rd_reg        <= 4'd0;
      rs_data_reg   <= 16'd0;
      rt_data_reg   <= 16'd0;
      imm_reg       <= 16'd0;
      valid_reg     <= 1'b0;
      halted_reg    <= 1'b0;
      stall_cnt_reg <= 16'd0;
    end else begin
      opcode_reg    <= opcode_next;
      rs_reg        <= rs_next;
      rt_reg        <= rt_next;
      rd_reg        <= rd_next;
      rs_data_reg   <= rs_data_next;
      rt_data_reg   <= rt_data_next;
      imm_reg       <= imm_next;
      valid_reg     <= valid_next;
      halted_reg    <= halted_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign ID_EX_Opcode  = opcode_reg;
  assign ID_EX_Rs      = rs_reg;
  assign ID_EX_Rt      = rt_reg;
  assign ID_EX_Rd      = rd_reg;
  assign ID_EX_Rs_Data = rs_data_reg;
  assign ID_EX_Rt_Data = rt_data_reg;
  assign ID_EX_Imm     = imm_reg;
  assign ID_EX_Valid   = valid_reg;
  assign Stall         = stall;
  assign Halted        = halted_reg;
  assign Stall_Cnt     = stall_cnt_reg;

endmodule

// File: tb/tb_id_ex_hazard.sv
// Bench for id_ex_hazard. A table of decode vectors with hand-derived expectations
// is applied one per cycle. Expected ID/EX contents go into a scoreboard queue when
// the vector is driven, and they are checked after the capturing edge. Hand-written
// sequences cover counter saturation and reset in the middle of a stall or halt.
module tb_id_ex_hazard;

  logic        clk;
  logic        rst_n;
  logic [3:0]  IF_ID_Opcode, IF_ID_Rs, IF_ID_Rt, IF_ID_Rd;
  logic [15:0] ID_Rs_Data, ID_Rt_Data, ID_Imm;
  logic        ID_Flush;
  logic [3:0]  ID_EX_Opcode, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
  logic [15:0] ID_EX_Rs_Data, ID_EX_Rt_Data, ID_EX_Imm;
  logic        ID_EX_Valid, Stall, Halted;
  logic [15:0] Stall_Cnt;

  id_ex_hazard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IF_ID_Opcode  (IF_ID_Opcode),
    .IF_ID_Rs      (IF_ID_Rs),
    .IF_ID_Rt      (IF_ID_Rt),
    .IF_ID_Rd      (IF_ID_Rd),
    .ID_Rs_Data    (ID_Rs_Data),
    .ID_Rt_Data    (ID_Rt_Data),
    .ID_Imm        (ID_Imm),
    .ID_Flush      (ID_Flush),
    .ID_EX_Opcode  (ID_EX_Opcode),
    .ID_EX_Rs      (ID_EX_Rs),
    .ID_EX_Rt      (ID_EX_Rt),
    .ID_EX_Rd      (ID_EX_Rd),
    .ID_EX_Rs_Data (ID_EX_Rs_Data),
    .ID_EX_Rt_Data (ID_EX_Rt_Data),
    .ID_EX_Imm     (ID_EX_Imm),
    .ID_EX_Valid   (ID_EX_Valid),
    .Stall         (Stall),
    .Halted        (Halted),
    .Stall_Cnt     (Stall_Cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One decode vector with the expected outcome of its cycle
  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [3:0]  rd;
    logic        flush;
    logic        exp_stall;
    logic        exp_valid;
    logic        exp_halt;
    logic [15:0] exp_cnt;
  } vec_t;

  // Scoreboard entry: the expected ID/EX state after the capturing edge
  typedef struct packed {
    logic [64:0] ex;
    logic        halt;
    logic [15:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tag = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (txn %0d): got %h required %h", name, tag, act, exp);
    end
  endtask

  function automatic logic [64:0] ex_actual();
    return {ID_EX_Opcode, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd,
            ID_EX_Rs_Data, ID_EX_Rt_Data, ID_EX_Imm, ID_EX_Valid};
  endfunction

  // Drive one decode instruction; the operand data is tagged so that each capture is unique
  task automatic drive(input logic [3:0] op, rs, rt, rd, input logic flush);
    tag++;
    IF_ID_Opcode = op;
    IF_ID_Rs     = rs;
    IF_ID_Rt     = rt;
    IF_ID_Rd     = rd;
    ID_Rs_Data   = 16'h1000 + 16'(tag);
    ID_Rt_Data   = 16'h2000 + 16'(tag);
    ID_Imm       = 16'h3000 + 16'(tag);
    ID_Flush     = flush;
  endtask

  task automatic push_exp(input logic valid, input logic halt, input logic [15:0] cnt);
    exp_t e;
    if (valid) begin
      e.ex = {IF_ID_Opcode, IF_ID_Rs, IF_ID_Rt, IF_ID_Rd, ID_Rs_Data, ID_Rt_Data, ID_Imm, 1'b1};
    end else begin
      e.ex = 65'd0;
    end
    e.halt = halt;
    e.cnt  = cnt;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard (txn %0d): got empty queue required one entry", tag);
    end else begin
      e = sb.pop_front();
      chk("id_ex", 80'(ex_actual()), 80'(e.ex));
      chk("halted", 80'(Halted), 80'(e.halt));
      chk("stall_cnt", 80'(Stall_Cnt), 80'(e.cnt));
      $display("txn %0d: op=%h rs=%h rd=%h valid=%b halted=%b stall_cnt=%h",
               tag, ID_EX_Opcode, ID_EX_Rs, ID_EX_Rd, ID_EX_Valid, Halted, Stall_Cnt);
    end
  endtask

  // Apply one cycle: drive at the falling edge, check Stall, then check ID/EX after the rising edge
  task automatic step(input vec_t v);
    @(negedge clk);
    drive(v.op, v.rs, v.rt, v.rd, v.flush);
    #1;
    chk("stall", 80'(Stall), 80'(v.exp_stall));
    push_exp(v.exp_valid, v.exp_halt, v.exp_cnt);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_id_ex"}, 80'(ex_actual()), 80'd0);
    chk({name, "_stall"}, 80'(Stall), 80'd0);
    chk({name, "_halted"}, 80'(Halted), 80'd0);
    chk({name, "_cnt"}, 80'(Stall_Cnt), 80'd0);
    $display("txn %0d: %s state valid=%b halted=%b stall_cnt=%h", tag, name, ID_EX_Valid, Halted, Stall_Cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 time units required earlier finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fields: op, rs, rt, rd, flush, exp_stall, exp_valid, exp_halt, exp_cnt
    vecs.push_back('{4'h0, 4'd1, 4'd2,  4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0}); // ADD R3
    vecs.push_back('{4'h8, 4'd1, 4'd0,  4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0}); // LW R3
    vecs.push_back('{4'h0, 4'd3, 4'd2,  4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 16'd1}); // ADD R5,R3,R2 stalls
    vecs.push_back('{4'h0, 4'd3, 4'd2,  4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 16'd1}); // captured after stall
    vecs.push_back('{4'h8, 4'd2, 4'd0,  4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 16'd1}); // LW R3
    vecs.push_back('{4'h9, 4'd4, 4'd3,  4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 16'd1}); // SW R3,[R4]: no stall
    vecs.push_back('{4'h8, 4'd2, 4'd0,  4'd4,  1'b0, 1'b0, 1'b1, 1'b0, 16'd1}); // LW R4
    vecs.push_back('{4'h9, 4'd4, 4'd3,  4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 16'd2}); // SW base R4 stalls
    vecs.push_back('{4'h9, 4'd4, 4'd3,  4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 16'd2});
    vecs.push_back('{4'h8, 4'd1, 4'd0,  4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 16'd2}); // LW R0
    vecs.push_back('{4'h0, 4'd0, 4'd0,  4'd1,  1'b0, 1'b0, 1'b1, 1'b0, 16'd2}); // ADD R1,R0,R0: no stall
    vecs.push_back('{4'h8, 4'd1, 4'd0,  4'd6,  1'b0, 1'b0, 1'b1, 1'b0, 16'd2}); // LW R6
    vecs.push_back('{4'h0, 4'd6, 4'd6,  4'd7,  1'b1, 1'b0, 1'b0, 1'b0, 16'd2}); // load-use with flush
    vecs.push_back('{4'h0, 4'd6, 4'd6,  4'd7,  1'b0, 1'b0, 1'b1, 1'b0, 16'd2}); // EX now a bubble
    vecs.push_back('{4'h8, 4'd1, 4'd0,  4'd7,  1'b0, 1'b0, 1'b1, 1'b0, 16'd2}); // LW R7
    vecs.push_back('{4'h8, 4'd7, 4'd0,  4'd8,  1'b0, 1'b1, 1'b0, 1'b0, 16'd3}); // LW after LW stalls
    vecs.push_back('{4'h8, 4'd7, 4'd0,  4'd8,  1'b0, 1'b0, 1'b1, 1'b0, 16'd3});
    vecs.push_back('{4'hA, 4'd8, 4'd0,  4'd8,  1'b0, 1'b1, 1'b0, 1'b0, 16'd4}); // 1010 reads Rs
    vecs.push_back('{4'hA, 4'd8, 4'd0,  4'd8,  1'b0, 1'b0, 1'b1, 1'b0, 16'd4});
    vecs.push_back('{4'h8, 4'd1, 4'd0,  4'd9,  1'b0, 1'b0, 1'b1, 1'b0, 16'd4}); // LW R9
    vecs.push_back('{4'hC, 4'd9, 4'd9,  4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 16'd4}); // 1100 has no sources
    vecs.push_back('{4'h8, 4'd1, 4'd0,  4'd10, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4}); // LW R10
    vecs.push_back('{4'h7, 4'd0, 4'd10, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 16'd5}); // 0111 reads Rt
    vecs.push_back('{4'h7, 4'd0, 4'd10, 4'd2,  1'b0, 1'b0, 1'b1, 1'b0, 16'd5});
    vecs.push_back('{4'h8, 4'd1, 4'd0,  4'd11, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5}); // LW R11
    vecs.push_back('{4'h4, 4'd1, 4'd11, 4'd2,  1'b0, 1'b0, 1'b1, 1'b0, 16'd5}); // 0100 ignores Rt
    vecs.push_back('{4'hF, 4'd0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 16'd5}); // HLT passes to EX
    vecs.push_back('{4'h0, 4'd1, 4'd2,  4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 16'd5}); // frozen after HLT
    vecs.push_back('{4'h8, 4'd1, 4'd0,  4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 16'd5});
    vecs.push_back('{4'h0, 4'd3, 4'd0,  4'd4,  1'b0, 1'b0, 1'b0, 1'b1, 16'd5});

    // Reset with a dependent-looking decode word present: outputs stay bubble/0
    rst_n = 1'b0;
    drive(4'h8, 4'd3, 4'd3, 4'd3, 1'b0);
    #3;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
    end

    // Reset while halted abandons the halt immediately
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("halt_reset");
    rst_n = 1'b1;

    // Preload the counter one below saturation, then apply three load-use stalls
    @(negedge clk);
    force dut.stall_cnt_reg = 16'hFFFE;
    #1;
    release dut.stall_cnt_reg;
    #1;
    chk("cnt_preload", 80'(Stall_Cnt), 80'h0FFFE);
    for (int k = 0; k < 3; k++) begin
      step('{4'h8, 4'd1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFE + 16'(k != 0)});
      step('{4'h0, 4'd3, 4'd2, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF});
      step('{4'h0, 4'd3, 4'd2, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF});
    end

    // Reset in the middle of a stall, then normal capture on the first edge after release
    step('{4'h8, 4'd1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF});
    @(negedge clk);
    drive(4'h0, 4'd3, 4'd2, 4'd5, 1'b0);
    #1;
    chk("mid_stall", 80'(Stall), 80'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state("stall_reset");
    rst_n = 1'b1;
    push_exp(1'b1, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    pop_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard.md
ID_EX_HAZARD -- requirements
Module: id_ex_hazard

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset, with all state held in clk-domain flops.
REQ-002 Port list, clock and reset first, SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- IF_ID_Opcode  in  4  opcode of the instruction in decode
- IF_ID_Rs, IF_ID_Rt, IF_ID_Rd  in  4 each  decoded register fields
- ID_Rs_Data, ID_Rt_Data  in  16 each  register-file read data
- ID_Imm  in  16  sign/zero-extended immediate
- ID_Flush  in  1  squash the decode instruction (taken branch)
- ID_EX_Opcode  out  4  registered opcode to EX; drives the forwarding logic
- ID_EX_Rs, ID_EX_Rt, ID_EX_Rd  out  4 each  registered register fields
- ID_EX_Rs_Data, ID_EX_Rt_Data, ID_EX_Imm  out  16 each  registered operands
- ID_EX_Valid  out  1  EX holds a real instruction
- Stall  out  1  freeze PC and IF/ID this cycle (combinational)
- Halted  out  1  HLT has entered EX; pipeline front end frozen
- Stall_Cnt  out  16  saturating count of load-use stall cycles

Function
REQ-003 Source-use decode of IF_ID_Opcode SHALL be:
- 0000-0011 and 0111: Rs and Rt
- 0100-0110, 1000, 1101: Rs only
- 1001: Rs, base only; store data is forwarded MEM-to-MEM, so no stall
- 1010, 1011: Rs only, carrying the old Rd value
- 1100, 1110, 1111: none
REQ-004 Stall SHALL be 1 only when all of the following hold: ID_EX_Valid=1; ID_EX_Opcode=4'b1000; ID_EX_Rd!=0; IF_ID_Rs or IF_ID_Rt matches ID_EX_Rd with that source used per REQ-003.
REQ-005 Stall SHALL be forced to 0 when ID_Flush=1 or Halted=1.
REQ-006 A bubble SHALL be: Opcode=4'b0000, Rs=Rt=Rd=0, Data/Imm=0, Valid=0; register 0 ensures downstream forwarding never matches a bubble.
REQ-007 Each rising edge SHALL load ID/EX per this priority:
- Halted=1: load a bubble
- ID_Flush=1: load a bubble
- Stall=1: load a bubble
- otherwise: capture all IF_ID_*/ID_* inputs with Valid=1
REQ-008 Latency from the decode inputs to the ID_EX_* outputs SHALL be exactly one cycle; a stalled instruction SHALL be captured on the cycle after its stall.
REQ-009 A load-use stall SHALL last exactly one cycle, because the bubble clears the REQ-004 condition.
REQ-010 Halted SHALL set on the edge at which an opcode 4'b1111 is captured with Valid=1, and SHALL stay set until reset.
REQ-011 The HLT instruction itself SHALL be passed through to EX; every later capture SHALL be a bubble.
REQ-012 Stall_Cnt SHALL increment by 1 on each edge where Stall=1, and SHALL saturate at 16'hFFFF with no wrap.
REQ-013 Stall and ID_Flush asserted together SHALL be handled as a flush: one bubble, Stall=0, no count increment.
REQ-014 A 1000 in decode that depends on a 1000 in EX SHALL stall in the same way as any other dependent instruction.
REQ-015 A match on register 0 SHALL never stall.
REQ-016 The outputs SHALL contain no combinational path from the ID_EX_* registers back into their own next-state logic other than through Stall.

Reset
REQ-017 While rst_n=0 the block SHALL immediately and asynchronously:
- load a bubble into ID/EX
- clear Halted
- clear Stall_Cnt
REQ-018 Stall SHALL read 0 during reset, since Valid=0.
REQ-019 Reset asserted mid-stall or mid-halt SHALL abandon that state; after rst_n rises, the first edge SHALL capture the decode inputs normally.

Verification
REQ-020 The bench SHALL cover at least the following directed scenarios:
- LW R3 in EX (valid), decode ADD R5,R3,R2 -> Stall=1 for one cycle, then a bubble (Valid=0, Rd=0) in EX, then ADD captured next edge with Rs=3; Stall_Cnt=1.
- LW R3 in EX, decode SW R3,[R4] (Rt=3, Rs=4) -> Stall=0, SW captured next edge; LW R4 in EX with the same SW -> Stall=1.
- LW R0 in EX, decode ADD R1,R0,R0 -> Stall=0.
- Load-use condition plus ID_Flush=1 in the same cycle -> Stall=0, bubble captured, Stall_Cnt unchanged.
- HLT captured -> Halted=1 next edge; the following 3 decode instructions produce Valid=0; Stall held 0.
- Force Stall_Cnt to 16'hFFFE, apply 3 load-use stalls -> count reads 16'hFFFF; rst_n pulsed low mid-stall -> all outputs return to bubble/0 before the next edge.
